// File: rtl/proc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle execution sequencer.
// State encodings are fixed because they appear on the debug state port.
package proc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE = 7'b0010011;

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_ILLEGAL = 2'b01;
  localparam logic [1:0] FLT_TIMEOUT = 2'b10;

  function automatic logic is_alu_opcode(input logic [6:0] opc);
    return (opc == OPC_RTYPE) || (opc == OPC_ITYPE);
  endfunction

endpackage

// File: rtl/imem_wait_timer.sv
// Counts FETCH cycles spent waiting for imem_ack. expired flags the
// increment that brings the count up to LIMIT.
module imem_wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

  assign expired = inc && (count == W'(LIMIT - 1));

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle controller stepping the datapath through fetch, decode,
// execute and writeback, with fetch timeout, opcode trap and single-step.
module exec_sequencer
  import proc_ctrl_pkg::*;
#(
  parameter int IMEM_TIMEOUT = 15,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             fault_clr,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [31:0]      instr,
  output logic [31:0]      ir,
  output logic             ir_load,
  output logic             alu_latch,
  output logic             reg_write,
  output logic             pc_en,
  output logic             busy,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  state_t             state_q, state_d;
  logic               step_q;
  logic               step_rise;
  logic [31:0]        ir_q;
  logic [1:0]         fault_code_q;
  logic [CNT_W-1:0]   retired_q;
  logic               in_fetch;
  logic               timer_expired;

  assign step_rise = step & ~step_q;
  assign in_fetch  = (state_q == ST_FETCH);

  imem_wait_timer #(
    .LIMIT (IMEM_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (!in_fetch || imem_ack),
    .inc     (in_fetch && !imem_ack),
    .expired (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      step_q       <= 1'b0;
      ir_q         <= '0;
      fault_code_q <= FLT_NONE;
      retired_q    <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step;
      if (in_fetch && imem_ack) ir_q <= instr;
      if (state_q == ST_WRITEBACK) retired_q <= retired_q + CNT_W'(1);
      // Fault code is latched on entry and held until the fault is cleared.
      if (in_fetch && !imem_ack && timer_expired) begin
        fault_code_q <= FLT_TIMEOUT;
      end else if (state_q == ST_DECODE && !is_alu_opcode(ir_q[6:0])) begin
        fault_code_q <= FLT_ILLEGAL;
      end else if (state_q == ST_FAULT && fault_clr) begin
        fault_code_q <= FLT_NONE;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    imem_req  = 1'b0;
    ir_load   = 1'b0;
    alu_latch = 1'b0;
    reg_write = 1'b0;
    pc_en     = 1'b0;
    busy      = 1'b1;
    fault     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (run || step_rise) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ack;
        if (imem_ack)           state_d = ST_DECODE;
        else if (timer_expired) state_d = ST_FAULT;
      end
      ST_DECODE: begin
        state_d = is_alu_opcode(ir_q[6:0]) ? ST_EXECUTE : ST_FAULT;
      end
      ST_EXECUTE: begin
        alu_latch = 1'b1;
        state_d   = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        reg_write = (ir_q[11:7] != 5'd0);
        pc_en     = 1'b1;
        state_d   = run ? ST_FETCH : ST_IDLE;
      end
      ST_FAULT: begin
        busy  = 1'b0;
        fault = 1'b1;
        if (fault_clr) state_d = ST_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ir         = ir_q;
  assign fault_code = fault_code_q;
  assign retired    = retired_q;
  assign state      = state_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: free-run, single-step, ack wait,
// fetch timeout, illegal opcode, rd=0, mid-instruction reset, counter wrap.
module tb_exec_sequencer;

  localparam int IMEM_TIMEOUT = 15;
  localparam int CNT_W        = 4;

  localparam logic [31:0] I_ADD    = 32'h002081B3;
  localparam logic [31:0] I_ADDI   = 32'h00A08093;
  localparam logic [31:0] I_BRANCH = 32'h00000063;
  localparam logic [31:0] I_RD0    = 32'h00208033;

  logic             clk = 1'b0;
  logic             reset;
  logic             run;
  logic             step;
  logic             fault_clr;
  logic             imem_req;
  logic             imem_ack;
  logic [31:0]      instr;
  logic [31:0]      ir;
  logic             ir_load;
  logic             alu_latch;
  logic             reg_write;
  logic             pc_en;
  logic             busy;
  logic             fault;
  logic [1:0]       fault_code;
  logic [CNT_W-1:0] retired;
  logic [2:0]       state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exec_sequencer #(
    .IMEM_TIMEOUT (IMEM_TIMEOUT),
    .CNT_W        (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .step       (step),
    .fault_clr  (fault_clr),
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .instr      (instr),
    .ir         (ir),
    .ir_load    (ir_load),
    .alu_latch  (alu_latch),
    .reg_write  (reg_write),
    .pc_en      (pc_en),
    .busy       (busy),
    .fault      (fault),
    .fault_code (fault_code),
    .retired    (retired),
    .state      (state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    run = 1'b0; step = 1'b0; fault_clr = 1'b0; imem_ack = 1'b0; instr = '0;

    // Reset state
    do_reset();
    check("rst_state", 32'(state), 32'd0);
    check("rst_ir", ir, 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_code", 32'(fault_code), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);

    // Free run, ack tied high, two back-to-back adds
    run = 1'b1; imem_ack = 1'b1; instr = I_ADD;
    for (int c = 1; c <= 8; c++) begin
      tick();
      check($sformatf("run_ir_load_c%0d", c), 32'(ir_load), 32'((c == 1) || (c == 5)));
      check($sformatf("run_reg_write_c%0d", c), 32'(reg_write), 32'((c == 4) || (c == 8)));
      check($sformatf("run_pc_en_c%0d", c), 32'(pc_en), 32'((c == 4) || (c == 8)));
      if (c == 8) run = 1'b0;
    end
    tick();
    check("run_retired", 32'(retired), 32'd2);
    check("run_idle", 32'(state), 32'd0);
    check("run_ir", ir, I_ADD);

    // Single step: one pulse, then a long held step
    do_reset();
    step = 1'b1;
    tick();
    step = 1'b0;
    check("step_fetch", 32'(state), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    check("step1_idle", 32'(state), 32'd0);
    check("step1_retired", 32'(retired), 32'd1);
    step = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    step = 1'b0;
    tick();
    tick();
    check("step2_idle", 32'(state), 32'd0);
    check("step2_retired", 32'(retired), 32'd2);

    // Ack arriving on the fourth FETCH cycle
    do_reset();
    imem_ack = 1'b0; instr = I_ADDI; run = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check($sformatf("wait_fetch_c%0d", c), 32'(state), 32'd1);
      check($sformatf("wait_req_c%0d", c), 32'(imem_req), 32'd1);
      check($sformatf("wait_noload_c%0d", c), 32'(ir_load), 32'd0);
    end
    tick();
    check("wait_fetch_c4", 32'(state), 32'd1);
    imem_ack = 1'b1; run = 1'b0;
    #1;
    check("wait_ir_load", 32'(ir_load), 32'd1);
    tick();
    imem_ack = 1'b0;
    check("wait_decode", 32'(state), 32'd2);
    check("wait_ir", ir, I_ADDI);
    tick();
    tick();
    tick();
    check("wait_idle", 32'(state), 32'd0);
    check("wait_retired", 32'(retired), 32'd1);

    // Fetch timeout: ack never arrives
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("clr_outside_fault", 32'(state), 32'd0);
    run = 1'b1;
    for (int c = 1; c <= IMEM_TIMEOUT; c++) begin
      tick();
      check($sformatf("to_fetch_c%0d", c), 32'(state), 32'd1);
    end
    tick();
    run = 1'b0;
    check("to_state", 32'(state), 32'd5);
    check("to_fault", 32'(fault), 32'd1);
    check("to_code", 32'(fault_code), 32'd2);
    check("to_busy", 32'(busy), 32'd0);
    check("to_req", 32'(imem_req), 32'd0);
    tick();
    check("to_hold_code", 32'(fault_code), 32'd2);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("to_clr_state", 32'(state), 32'd0);
    check("to_clr_fault", 32'(fault), 32'd0);
    check("to_clr_code", 32'(fault_code), 32'd0);

    // Illegal opcode trap
    instr = I_BRANCH; imem_ack = 1'b1; run = 1'b1;
    tick();
    tick();
    run = 1'b0;
    check("ill_decode", 32'(state), 32'd2);
    tick();
    check("ill_state", 32'(state), 32'd5);
    check("ill_code", 32'(fault_code), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ill_no_pc_%0d", i), 32'(pc_en), 32'd0);
      check($sformatf("ill_no_wr_%0d", i), 32'(reg_write), 32'd0);
      tick();
    end
    check("ill_retired", 32'(retired), 32'd1);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("ill_clr", 32'(state), 32'd0);

    // rd = x0: PC advances, no register write
    instr = I_RD0;
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    tick();
    tick();
    check("rd0_wb", 32'(state), 32'd4);
    check("rd0_pc_en", 32'(pc_en), 32'd1);
    check("rd0_reg_write", 32'(reg_write), 32'd0);
    tick();
    check("rd0_retired", 32'(retired), 32'd2);

    // Reset during EXECUTE aborts the instruction
    instr = I_ADD; run = 1'b1;
    tick();
    tick();
    tick();
    check("abort_exec", 32'(state), 32'd3);
    check("abort_alu_latch", 32'(alu_latch), 32'd1);
    reset = 1'b0;
    tick();
    check("abort_state", 32'(state), 32'd0);
    check("abort_retired", 32'(retired), 32'd0);
    check("abort_reg_write", 32'(reg_write), 32'd0);
    check("abort_pc_en", 32'(pc_en), 32'd0);
    reset = 1'b1;

    // Retired counter wraps after 16 instructions
    for (int c = 1; c <= 64; c++) tick();
    check("wrap_wb", 32'(state), 32'd4);
    check("wrap_pre", 32'(retired), 32'd15);
    run = 1'b0;
    tick();
    check("wrap_state", 32'(state), 32'd0);
    check("wrap_retired", 32'(retired), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
